// File: rtl/worker_cpu_cpu_mul_arb_pkg.sv
// Shared types and constants for the two-requester 32x32 multiplier arbiter.
// The 32-bit product is built from three 16x16 partial products.
package worker_cpu_cpu_mul_arb_pkg;

  localparam int DATA_W          = 32;
  localparam int HALF_W          = 16;
  localparam int MUL_LATENCY_DEF = 1;
  localparam int CNT_W           = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMBINE,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] p1;
    logic [DATA_W-1:0] p2;
    logic [DATA_W-1:0] p3;
  } part_prod_t;

  // lo*lo + (hi*lo + lo*hi) << 16; the hi*hi term lies entirely above bit 31
  function automatic logic [DATA_W-1:0] combine_partials(
    input logic [DATA_W-1:0] p1,
    input logic [DATA_W-1:0] p2,
    input logic [DATA_W-1:0] p3
  );
    logic [DATA_W-1:0] mid;
    mid = p2 + p3;
    return p1 + (mid << HALF_W);
  endfunction

endpackage

// File: rtl/worker_cpu_cpu_mul_arb_if.sv
// Request/response bundle between two requesters, one consumer and the multiplier arbiter.
interface worker_cpu_cpu_mul_arb_if;
  import worker_cpu_cpu_mul_arb_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_src1;
  logic [DATA_W-1:0] req0_src2;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_src1;
  logic [DATA_W-1:0] req1_src2;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req0_valid, req0_src1, req0_src2,
    output req1_valid, req1_src1, req1_src2,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req0_valid, req0_src1, req0_src2,
    input  req1_valid, req1_src1, req1_src2,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data
  );

endinterface

// File: rtl/worker_cpu_cpu_mult_cell.sv
// Pipelined 16x16 partial-product cell; outputs are valid MUL_LATENCY cycles after M_en.
// Registers are cleared while reset_n is low.
module worker_cpu_cpu_mult_cell
  import worker_cpu_cpu_mul_arb_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              M_en,
  output logic [DATA_W-1:0] M_mul_cell_p1,
  output logic [DATA_W-1:0] M_mul_cell_p2,
  output logic [DATA_W-1:0] M_mul_cell_p3
);

  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  part_prod_t        prod_calc;
  part_prod_t        pipe_reg [MUL_LATENCY];

  assign a_lo = E_src1[HALF_W-1:0];
  assign a_hi = E_src1[DATA_W-1:HALF_W];
  assign b_lo = E_src2[HALF_W-1:0];
  assign b_hi = E_src2[DATA_W-1:HALF_W];

  assign prod_calc.p1 = DATA_W'(a_lo) * DATA_W'(b_lo);
  assign prod_calc.p2 = DATA_W'(a_hi) * DATA_W'(b_lo);
  assign prod_calc.p3 = DATA_W'(a_lo) * DATA_W'(b_hi);

  // First stage captures only while enabled; later stages just carry it forward.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pipe_reg[i] <= '0;
      end
    end else begin
      if (M_en) begin
        pipe_reg[0] <= prod_calc;
      end
      for (int i = 1; i < MUL_LATENCY; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  assign M_mul_cell_p1 = pipe_reg[MUL_LATENCY-1].p1;
  assign M_mul_cell_p2 = pipe_reg[MUL_LATENCY-1].p2;
  assign M_mul_cell_p3 = pipe_reg[MUL_LATENCY-1].p3;

endmodule

// File: rtl/worker_cpu_cpu_mul_arb.sv
// Round-robin arbiter in front of a shared 32x32 (low-word) unsigned multiplier.
// One operation in flight; result held in RESP until the consumer takes it.
module worker_cpu_cpu_mul_arb
  import worker_cpu_cpu_mul_arb_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  worker_cpu_cpu_mul_arb_if.slave bus,
  output logic                    busy
);

  arb_state_e        state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] resp_data_reg, resp_data_next;
  logic [DATA_W-1:0] src1_reg, src2_reg;
  logic              id_reg;

  logic              grant0, grant1, accept, mul_en;
  logic [DATA_W-1:0] mul_p1, mul_p2, mul_p3;

  // Grants only exist in IDLE, so readiness drops for the whole operation.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_reg == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant_reg;
        grant1 = ~last_grant_reg;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign accept         = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    resp_data_next  = resp_data_reg;
    mul_en          = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next      = ISSUE;
          last_grant_next = grant1;
        end
      end
      ISSUE: begin
        mul_en     = 1'b1;
        cnt_next   = CNT_W'(MUL_LATENCY - 1);
        state_next = (MUL_LATENCY == 1) ? COMBINE : WAIT;
      end
      WAIT: begin
        mul_en   = 1'b1;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = COMBINE;
        end
      end
      COMBINE: begin
        resp_data_next = combine_partials(mul_p1, mul_p2, mul_p3);
        state_next     = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      resp_data_reg  <= '0;
      src1_reg       <= '0;
      src2_reg       <= '0;
      id_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      resp_data_reg  <= resp_data_next;
      if (accept) begin
        src1_reg <= grant1 ? bus.req1_src1 : bus.req0_src1;
        src2_reg <= grant1 ? bus.req1_src2 : bus.req0_src2;
        id_reg   <= grant1;
      end
    end
  end

  worker_cpu_cpu_mult_cell #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mult_cell (
    .E_src1        (src1_reg),
    .E_src2        (src2_reg),
    .M_en          (mul_en),
    .clk           (clk),
    .reset_n       (reset_n),
    .M_mul_cell_p1 (mul_p1),
    .M_mul_cell_p2 (mul_p2),
    .M_mul_cell_p3 (mul_p3)
  );

  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_id    = id_reg;
  assign bus.resp_data  = resp_data_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_worker_cpu_cpu_mul_arb.sv
// Directed bench: three arbiters (latency 1, 3, 4) on one clock, hand-computed products.
module tb_worker_cpu_cpu_mul_arb;
  import worker_cpu_cpu_mul_arb_pkg::*;

  localparam int N_DUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n_tb    [N_DUT];
  logic        req0_valid_tb [N_DUT];
  logic        req1_valid_tb [N_DUT];
  logic [31:0] req0_src1_tb  [N_DUT];
  logic [31:0] req0_src2_tb  [N_DUT];
  logic [31:0] req1_src1_tb  [N_DUT];
  logic [31:0] req1_src2_tb  [N_DUT];
  logic        resp_ready_tb [N_DUT];
  logic        req0_ready_tb [N_DUT];
  logic        req1_ready_tb [N_DUT];
  logic        resp_valid_tb [N_DUT];
  logic        resp_id_tb    [N_DUT];
  logic [31:0] resp_data_tb  [N_DUT];
  logic        busy_tb       [N_DUT];

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
    worker_cpu_cpu_mul_arb_if u_bus ();
    assign u_bus.req0_valid = req0_valid_tb[gi];
    assign u_bus.req0_src1  = req0_src1_tb[gi];
    assign u_bus.req0_src2  = req0_src2_tb[gi];
    assign u_bus.req1_valid = req1_valid_tb[gi];
    assign u_bus.req1_src1  = req1_src1_tb[gi];
    assign u_bus.req1_src2  = req1_src2_tb[gi];
    assign u_bus.resp_ready = resp_ready_tb[gi];
    assign req0_ready_tb[gi] = u_bus.req0_ready;
    assign req1_ready_tb[gi] = u_bus.req1_ready;
    assign resp_valid_tb[gi] = u_bus.resp_valid;
    assign resp_id_tb[gi]    = u_bus.resp_id;
    assign resp_data_tb[gi]  = u_bus.resp_data;

    worker_cpu_cpu_mul_arb #(
      .MUL_LATENCY (LAT)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n_tb[gi]),
      .bus     (u_bus),
      .busy    (busy_tb[gi])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call just after the accept edge; lat counts edges starting with the accept edge.
  task automatic wait_resp(input int d, output int lat);
    lat = 1;
    while (resp_valid_tb[d] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input int d, input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    int lat;
    if (r == 0) begin
      req0_valid_tb[d] = 1'b1; req0_src1_tb[d] = a; req0_src2_tb[d] = b;
    end else begin
      req1_valid_tb[d] = 1'b1; req1_src1_tb[d] = a; req1_src2_tb[d] = b;
    end
    resp_ready_tb[d] = 1'b1;
    #1;
    check_eq({tag, "_ready"}, 32'((r == 0) ? req0_ready_tb[d] : req1_ready_tb[d]), 32'd1);
    check_eq({tag, "_other_ready"}, 32'((r == 0) ? req1_ready_tb[d] : req0_ready_tb[d]), 32'd0);
    tick();
    req0_valid_tb[d] = 1'b0;
    req1_valid_tb[d] = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy_tb[d]), 32'd1);
    wait_resp(d, lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'(lat_of(d) + 2));
    check_eq({tag, "_data"}, resp_data_tb[d], exp);
    check_eq({tag, "_id"}, 32'(resp_id_tb[d]), 32'(r));
    $display("op dut=%0d req=%0d 0x%08h x 0x%08h -> id=%0d data=0x%08h lat=%0d",
             d, r, a, b, resp_id_tb[d], resp_data_tb[d], lat);
    tick();
    check_eq({tag, "_idle_valid"}, 32'(resp_valid_tb[d]), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy_tb[d]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        seen;
    logic [31:0] held;

    for (int d = 0; d < N_DUT; d++) begin
      reset_n_tb[d] = 1'b0;
      req0_valid_tb[d] = 1'b0; req1_valid_tb[d] = 1'b0;
      req0_src1_tb[d] = '0; req0_src2_tb[d] = '0;
      req1_src1_tb[d] = '0; req1_src2_tb[d] = '0;
      resp_ready_tb[d] = 1'b0;
    end
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy_tb[0]), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid_tb[0]), 32'd0);
    check_eq("rst_resp_id", 32'(resp_id_tb[0]), 32'd0);
    check_eq("rst_resp_data", resp_data_tb[0], 32'd0);
    check_eq("rst_req0_ready", 32'(req0_ready_tb[0]), 32'd0);
    for (int d = 0; d < N_DUT; d++) reset_n_tb[d] = 1'b1;
    tick();
    check_eq("post_rst_busy", 32'(busy_tb[0]), 32'd0);

    // After reset both valid -> req0 wins; withdrawn before any edge
    req0_valid_tb[0] = 1'b1; req1_valid_tb[0] = 1'b1;
    #1;
    check_eq("first_grant_r0", 32'(req0_ready_tb[0]), 32'd1);
    check_eq("first_grant_r1", 32'(req1_ready_tb[0]), 32'd0);
    req0_valid_tb[0] = 1'b0; req1_valid_tb[0] = 1'b0;
    #1;

    do_op(0, 0, 32'h0001_0002, 32'h0003_0004, 32'h000A_0008, "basic_r0");
    do_op(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "ovf_r1");

    // Both requesters held valid for four operations
    req0_valid_tb[0] = 1'b1; req0_src1_tb[0] = 32'd3; req0_src2_tb[0] = 32'd5;
    req1_valid_tb[0] = 1'b1; req1_src1_tb[0] = 32'h0001_0003; req1_src2_tb[0] = 32'h0001_0005;
    resp_ready_tb[0] = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("rr_both_ready", 32'(req0_ready_tb[0] & req1_ready_tb[0]), 32'd0);
      check_eq("rr_grant_r1", 32'(req1_ready_tb[0]), 32'(k % 2));
      check_eq("rr_grant_r0", 32'(req0_ready_tb[0]), 32'((k + 1) % 2));
      tick();
      check_eq("rr_ready_in_op", 32'(req0_ready_tb[0] | req1_ready_tb[0]), 32'd0);
      wait_resp(0, lat);
      check_eq("rr_latency", 32'(lat), 32'd3);
      check_eq("rr_id", 32'(resp_id_tb[0]), 32'(k % 2));
      check_eq("rr_data", resp_data_tb[0], (k % 2 == 1) ? 32'h0008_000F : 32'h0000_000F);
      $display("op dut=0 rr k=%0d -> id=%0d data=0x%08h lat=%0d", k, resp_id_tb[0], resp_data_tb[0], lat);
      tick();
    end
    req0_valid_tb[0] = 1'b0; req1_valid_tb[0] = 1'b0;
    #1;

    // Backpressure: single req1 wins although it was granted last
    resp_ready_tb[0] = 1'b0;
    req1_valid_tb[0] = 1'b1; req1_src1_tb[0] = 32'h0002_0001; req1_src2_tb[0] = 32'h0000_0007;
    #1;
    check_eq("bp_r1_ready", 32'(req1_ready_tb[0]), 32'd1);
    tick();
    req1_valid_tb[0] = 1'b0;
    req1_src1_tb[0] = 32'hDEAD_BEEF;
    wait_resp(0, lat);
    check_eq("bp_latency", 32'(lat), 32'd3);
    check_eq("bp_data", resp_data_tb[0], 32'h000E_0007);
    check_eq("bp_id", 32'(resp_id_tb[0]), 32'd1);
    held = resp_data_tb[0];
    req0_valid_tb[0] = 1'b1; req0_src1_tb[0] = 32'h0000_FFFF; req0_src2_tb[0] = 32'h0000_FFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("bp_hold_valid", 32'(resp_valid_tb[0]), 32'd1);
      check_eq("bp_hold_data", resp_data_tb[0], 32'h000E_0007);
      check_eq("bp_hold_id", 32'(resp_id_tb[0]), 32'd1);
      check_eq("bp_hold_ready", 32'(req0_ready_tb[0]), 32'd0);
    end
    $display("op dut=0 req=1 held 5 cycles data=0x%08h", held);
    resp_ready_tb[0] = 1'b1;
    #1;
    check_eq("bp_handshake_ready", 32'(req0_ready_tb[0]), 32'd0);
    tick();
    check_eq("bp_bubble_valid", 32'(resp_valid_tb[0]), 32'd0);
    check_eq("bp_bubble_busy", 32'(busy_tb[0]), 32'd0);
    check_eq("bp_bubble_ready", 32'(req0_ready_tb[0]), 32'd1);
    tick();
    req0_valid_tb[0] = 1'b0;
    wait_resp(0, lat);
    check_eq("bp_next_data", resp_data_tb[0], 32'hFFFE_0001);
    check_eq("bp_next_id", 32'(resp_id_tb[0]), 32'd0);
    $display("op dut=0 req=0 0x0000ffff x 0x0000ffff -> data=0x%08h lat=%0d", resp_data_tb[0], lat);
    tick();

    // Reset during WAIT on the latency-3 instance
    req0_valid_tb[1] = 1'b1; req0_src1_tb[1] = 32'd9; req0_src2_tb[1] = 32'd11;
    resp_ready_tb[1] = 1'b1;
    #1;
    check_eq("l3_ready", 32'(req0_ready_tb[1]), 32'd1);
    tick();
    req0_valid_tb[1] = 1'b0;
    tick();
    check_eq("l3_wait_busy", 32'(busy_tb[1]), 32'd1);
    #2;
    reset_n_tb[1] = 1'b0;
    #1;
    check_eq("l3_rst_busy", 32'(busy_tb[1]), 32'd0);
    check_eq("l3_rst_valid", 32'(resp_valid_tb[1]), 32'd0);
    tick();
    tick();
    reset_n_tb[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (resp_valid_tb[1] === 1'b1) seen = 1'b1;
    end
    check_eq("l3_no_resp", 32'(seen), 32'd0);
    $display("op dut=1 req=0 9 x 11 discarded by reset");
    do_op(1, 0, 32'd7, 32'd6, 32'h0000_002A, "l3_after_rst");

    do_op(2, 0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, "l4_big");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/worker_cpu_cpu_mul_arb.md
WORKER_CPU_CPU_MUL_ARB -- requirements
Module: worker_cpu_cpu_mul_arb

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 1: cycles from mul_en high to valid partial products (range 1..4).
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each: requester operand pair valid.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1 each: request accepted this cycle.
REQ-006 SHALL have ports req0_src1, req0_src2, req1_src1, req1_src2, input, 32 each: operands.
REQ-007 SHALL have port resp_valid, output, 1: result available.
REQ-008 SHALL have port resp_ready, input, 1: consumer accepts result.
REQ-009 SHALL have port resp_id, output, 1: requester index owning the result.
REQ-010 SHALL have port resp_data, output, 32: low 32 bits of src1*src2.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, COMBINE, RESP.
REQ-013 IDLE: reqN_ready = grant to N; on valid&ready, latch operands and id, go to ISSUE next cycle.
REQ-014 Arbitration SHALL be round-robin: single valid wins; both valid -> requester other than last_grant wins; last_grant resets to 1, so req0 wins first.
REQ-015 req0_ready and req1_ready SHALL be zero outside IDLE and never both high.
REQ-016 ISSUE: drive latched operands to the multiplier, mul_en=1 for exactly one cycle, load wait counter with MUL_LATENCY-1; go WAIT, or COMBINE if MUL_LATENCY=1.
REQ-017 WAIT: hold operands, mul_en=1, decrement counter; go COMBINE when counter reaches 0.
REQ-018 COMBINE: resp_data register <= p1 + ((p2 + p3) << 16), truncated to 32 bits; go RESP.
REQ-019 RESP: resp_valid=1, resp_data/resp_id stable; on resp_ready go IDLE; otherwise hold indefinitely (backpressure).
REQ-020 Latency SHALL be MUL_LATENCY+2 cycles from accept edge to resp_valid high (3 for default).
REQ-021 A new request SHALL NOT be accepted in the cycle resp handshake completes; one-cycle IDLE bubble minimum between operations.
REQ-022 Inputs changing while not ready SHALL have no effect; latched operands only.
REQ-023 Products SHALL be unsigned; all overflow beyond bit 31 discarded.

Reset
REQ-024 reset_n low SHALL asynchronously force IDLE, last_grant=1, counter=0, resp_valid=0, resp_id=0, resp_data=0, busy=0, mul_en=0.
REQ-025 Reset mid-operation SHALL discard the in-flight operation with no response generated.
REQ-026 Multiplier cell clear SHALL be driven from ~reset_n.

Structure
REQ-027 Shared package SHALL hold the FSM state enumeration, data width 32, half width 16, and MUL_LATENCY default.
REQ-028 SHALL instantiate one sub-module worker_cpu_cpu_mult_cell (ports E_src1, E_src2, M_en, clk, reset_n, M_mul_cell_p1..p3), driven from the latched operands and mul_en.

Verification
REQ-029 req0 0x00010002 x 0x00030004 -> resp_valid 3 cycles after accept, resp_data 0x000A0008, resp_id 0.
REQ-030 req1 0xFFFFFFFF x 0xFFFFFFFF -> resp_data 0x00000001, resp_id 1.
REQ-031 Both valid continuously for 4 ops -> grants 0,1,0,1; never both ready.
REQ-032 resp_ready low 5 cycles in RESP -> resp_valid/data held stable, req ready low, then release -> IDLE with one bubble.
REQ-033 reset_n pulsed low during WAIT (MUL_LATENCY=3) -> immediate IDLE, busy 0, no resp_valid; next op 7 x 6 -> 0x0000002A.
REQ-034 MUL_LATENCY=4, 0x12345678 x 0x9ABCDEF0 -> resp_data 0x242D2080 after 6 cycles.
